// File: rtl/mc_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a mem_ready handshake.
// The instruction class is latched in DECODE so that every later strobe depends only on state.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [2:0] alu_select,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       alu_out_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsAnd, ClsOr, ClsAdd, ClsSub, ClsAndi, ClsOri, ClsAddi,
    ClsLui, ClsLw, ClsSw, ClsBeq, ClsJ, ClsIllegal
  } cls_e;

  state_e state_q, state_d;
  cls_e   class_q, dec_cls;

  always_comb begin
    dec_cls = ClsIllegal;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24:   dec_cls = ClsAnd;
          6'h25:   dec_cls = ClsOr;
          6'h20:   dec_cls = ClsAdd;
          6'h22:   dec_cls = ClsSub;
          default: dec_cls = ClsIllegal;
        endcase
      end
      6'h0C:   dec_cls = ClsAndi;
      6'h0D:   dec_cls = ClsOri;
      6'h08:   dec_cls = ClsAddi;
      6'h0F:   dec_cls = ClsLui;
      6'h23:   dec_cls = ClsLw;
      6'h2B:   dec_cls = ClsSw;
      6'h04:   dec_cls = ClsBeq;
      6'h02:   dec_cls = ClsJ;
      default: dec_cls = ClsIllegal;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      class_q <= ClsNone;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        class_q <= dec_cls;
      end
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: state_d = (dec_cls == ClsIllegal) ? StFetch : StExec;
      StExec: begin
        case (class_q)
          ClsLw, ClsSw: state_d = StMem;
          ClsAnd, ClsOr, ClsAdd, ClsSub, ClsAndi, ClsOri, ClsAddi, ClsLui: state_d = StWb;
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        if (!mem_ready) begin
          state_d = StMem;
        end else if (class_q == ClsLw) begin
          state_d = StWb;
        end else begin
          state_d = StFetch;
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    alu_select    = 3'b000;
    alu_src_b     = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_inc        = 1'b0;
    pc_write      = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    instr_done    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_inc   = mem_ready;
      end
      StDecode: begin
        illegal    = (dec_cls == ClsIllegal);
        instr_done = (dec_cls == ClsIllegal);
      end
      StExec: begin
        alu_out_write = 1'b1;
        case (class_q)
          ClsAnd:  alu_select = 3'b000;
          ClsOr:   alu_select = 3'b001;
          ClsAdd:  alu_select = 3'b010;
          ClsSub:  alu_select = 3'b011;
          ClsAndi: begin alu_select = 3'b000; alu_src_b = 2'd2; end
          ClsOri:  begin alu_select = 3'b001; alu_src_b = 2'd2; end
          ClsAddi, ClsLw, ClsSw: begin alu_select = 3'b010; alu_src_b = 2'd1; end
          ClsLui:  begin alu_select = 3'b100; alu_src_b = 2'd3; end
          ClsBeq, ClsJ: begin
            alu_select    = (class_q == ClsBeq) ? 3'b101 : 3'b110;
            alu_out_write = 1'b0;
            pc_write      = 1'b1;
            instr_done    = 1'b1;
          end
          default: alu_out_write = 1'b0;
        endcase
      end
      StMem: begin
        iord       = 1'b1;
        mem_read   = (class_q == ClsLw);
        mem_write  = (class_q == ClsSw);
        mdr_write  = (class_q == ClsLw) && mem_ready;
        instr_done = (class_q == ClsSw) && mem_ready;
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst    = (class_q inside {ClsAnd, ClsOr, ClsAdd, ClsSub});
        mem_to_reg = (class_q == ClsLw);
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset kills any in-flight request immediately, without waiting for a clock edge.
    if (rst) begin
      alu_select    = 3'b000;
      alu_src_b     = 2'd0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_inc        = 1'b0;
      pc_write      = 1'b0;
      alu_out_write = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal       = 1'b0;
      instr_done    = 1'b0;
    end
  end

  assign state = state_q;

endmodule
